// File: rtl/usb_stream_arbiter.sv
// Packet-atomic round-robin arbiter merging COBS byte streams onto one USB FIFO stream.
// Optional mid-packet stall timeout with COBS-delimiter abort: define USB_ARB_TIMEOUT_EN.
module usb_stream_arbiter #(
    parameter int NUM_SOURCES    = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_SOURCES-1:0]            s_tvalid,
    input  logic [NUM_SOURCES-1:0]            s_tlast,
    output logic [NUM_SOURCES-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]             m_tdata,
    output logic                              m_tvalid,
    output logic                              m_tlast,
    input  logic                              m_tready,
    output logic [NUM_SOURCES-1:0]            grant,
    output logic                              busy,
    output logic                              timeout_err,
    input  logic                              err_clear
);
    localparam int PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

`ifdef USB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, FORWARD, ABORT} state_t;
`else
    typedef enum logic {IDLE, FORWARD} state_t;
`endif

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [NUM_SOURCES-1:0]  grant_q, grant_d;
    logic                    m_tvalid_q, m_tlast_q;
    logic [DATA_WIDTH-1:0]   m_tdata_q;
    logic                    out_ready, fwd_hs, fwd_last, stall_fire;
    logic [NUM_SOURCES-1:0]  req, drop_q;
    logic                    found;
    logic [PTR_W-1:0]        winner;
    int                      idx;

    assign out_ready = !m_tvalid_q || m_tready;
    assign fwd_hs    = (state_q == FORWARD) && s_tvalid[ptr_q] && out_ready;
    assign fwd_last  = fwd_hs && s_tlast[ptr_q];

`ifdef USB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] stall_q;
    logic             timeout_err_q;

    assign stall_fire = (state_q == FORWARD) && !s_tvalid[ptr_q]
                        && (stall_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q != FORWARD || fwd_hs)
                stall_q <= '0;
            else if (!s_tvalid[ptr_q])
                stall_q <= stall_q + 1'b1;
            if (stall_fire)
                timeout_err_q <= 1'b1;
            else if (err_clear)
                timeout_err_q <= 1'b0;
        end
    end

    // An aborted source keeps draining its packet into the void until its tlast.
    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_drop
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                drop_q[gi] <= 1'b0;
            else if (stall_fire && ptr_q == PTR_W'(gi))
                drop_q[gi] <= 1'b1;
            else if (drop_q[gi] && s_tvalid[gi] && s_tlast[gi])
                drop_q[gi] <= 1'b0;
        end
    end

    assign req         = s_tvalid & ~drop_q;
    assign timeout_err = timeout_err_q;
`else
    logic unused_ok;
    assign unused_ok   = err_clear ^ (TIMEOUT_CYCLES > 0);
    assign stall_fire  = 1'b0;
    assign drop_q      = '0;
    assign req         = s_tvalid;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        found   = 1'b0;
        winner  = ptr_q;
        idx     = 0;
        // First requester strictly after the last owner, wrapping around.
        for (int k = 1; k <= NUM_SOURCES; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_SOURCES)
                idx = idx - NUM_SOURCES;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d         = FORWARD;
                    ptr_d           = winner;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                end
            end
            FORWARD: begin
                if (fwd_last) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (stall_fire) begin
`ifdef USB_ARB_TIMEOUT_EN
                    state_d = ABORT;
`endif
                    grant_d = '0;
                end
            end
`ifdef USB_ARB_TIMEOUT_EN
            ABORT: begin
                if (out_ready)
                    state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PTR_W'(NUM_SOURCES - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
        end else if (fwd_hs) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= s_tdata[ptr_q*DATA_WIDTH +: DATA_WIDTH];
            m_tlast_q  <= s_tlast[ptr_q];
`ifdef USB_ARB_TIMEOUT_EN
        end else if (state_q == ABORT && out_ready) begin
            // Lone zero byte with tlast: COBS delimiter so the host resynchronises.
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b1;
`endif
        end else if (m_tready) begin
            m_tvalid_q <= 1'b0;
        end
    end

    assign s_tready = ((state_q == FORWARD && out_ready) ? grant_q : '0) | drop_q;
    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_usb_stream_arbiter.sv
// Randomized bench for usb_stream_arbiter: packet-level round-robin model and output scoreboard.
module tb_usb_stream_arbiter;
    localparam int NS  = 2;
    localparam int DW  = 8;
    localparam int TRN = 256;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NS*DW-1:0] s_tdata;
    logic [NS-1:0]    s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]    m_tdata;
    logic             m_tvalid, m_tlast, m_tready;
    logic [NS-1:0]    grant;
    logic             busy, timeout_err, err_clear;

    usb_stream_arbiter #(
        .NUM_SOURCES(NS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .grant(grant), .busy(busy), .timeout_err(timeout_err), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Per-source byte queues {last, data}; expected output byte stream.
    logic [8:0]    srcq [NS][$];
    logic [8:0]    exp_q[$];
    int            hold_cnt[NS], stall_after[NS], stall_len[NS], popped[NS];
    bit            mid[NS];
    int            stall_pct, tready_mode, cyc_i, model_ptr;
    bit            chk_hold_grant, prev_held;
    bit            tr_valid[TRN], tr_last[TRN], tr_busy[TRN];
    logic [NS-1:0] tr_grant[TRN];

    task automatic clear_tb_state();
        for (int s = 0; s < NS; s++) begin
            srcq[s].delete();
            hold_cnt[s] = 0; stall_after[s] = 0; stall_len[s] = 0; popped[s] = 0; mid[s] = 0;
        end
        exp_q.delete();
        stall_pct = 0; tready_mode = 0; chk_hold_grant = 0; prev_held = 0; cyc_i = 0;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1; err_clear = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_tb_state();
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = NS - 1;
    endtask

    task automatic add_pkt(input int s, input int len, input int first, input bit rnd);
        logic [7:0] v;
        for (int i = 0; i < len; i++) begin
            v = rnd ? 8'($urandom_range(0, 255)) : 8'(first + i);
            srcq[s].push_back({(i == len - 1), v});
        end
    endtask

    // Every source has all its packets queued from the start: each gets one whole packet per turn.
    task automatic build_expected();
        logic [8:0] cp [NS][$];
        logic [8:0] b;
        int pick;
        for (int s = 0; s < NS; s++) cp[s] = srcq[s];
        forever begin
            pick = -1;
            for (int k = 1; k <= NS; k++)
                if (pick < 0 && cp[(model_ptr + k) % NS].size() > 0) pick = (model_ptr + k) % NS;
            if (pick < 0) break;
            do begin
                b = cp[pick].pop_front();
                exp_q.push_back(b);
            end while (!b[8] && cp[pick].size() > 0);
            model_ptr = pick;
        end
    endtask

    task automatic drive_inputs();
        logic [NS*DW-1:0] d;
        logic [NS-1:0]    v, l;
        d = '0; v = '0; l = '0;
        for (int s = 0; s < NS; s++) begin
            if (srcq[s].size() > 0) begin
                if (hold_cnt[s] > 0) begin
                    hold_cnt[s]--;
                    v[s] = 1'b0;
                end else if (mid[s] && $urandom_range(0, 99) < stall_pct) v[s] = 1'b0;
                else v[s] = 1'b1;
                d[s*DW +: DW] = srcq[s][0][7:0];
                l[s]          = srcq[s][0][8];
            end
        end
        s_tdata = d; s_tvalid = v; s_tlast = l;
        case (tready_mode)
            1:       m_tready = ($urandom_range(0, 99) < 70);
            2:       m_tready = (cyc_i % 3 == 0);
            default: m_tready = 1'b1;
        endcase
    endtask

    task automatic one_cycle();
        logic [NS-1:0] hs;
        logic [8:0]    b;
        @(negedge clk);
        drive_inputs();
        #1;
        if (cyc_i < TRN) begin
            tr_valid[cyc_i] = m_tvalid; tr_last[cyc_i] = m_tlast;
            tr_busy[cyc_i]  = busy;     tr_grant[cyc_i] = grant;
        end
        if (prev_held) check("held_valid", m_tvalid, 1);
        check("grant_onehot0", $onehot0(grant), 1);
        if (chk_hold_grant && mid[0] && !s_tvalid[0]) check("stall_keeps_grant", grant, 1);
        if (m_tvalid) begin
            if (exp_q.size() == 0) check("unexpected_byte", m_tvalid, 0);
            else begin
                check("out_data", m_tdata, exp_q[0][7:0]);
                check("out_last", m_tlast, exp_q[0][8]);
                if (m_tready) void'(exp_q.pop_front());
            end
        end
        prev_held = m_tvalid && !m_tready;
        hs = s_tvalid & s_tready;
        @(posedge clk);
        for (int s = 0; s < NS; s++) begin
            if (hs[s] && srcq[s].size() > 0) begin
                b = srcq[s].pop_front();
                popped[s]++;
                mid[s] = !b[8];
                if (b[8]) popped[s] = 0;
                else if (stall_after[s] != 0 && popped[s] == stall_after[s]) hold_cnt[s] = stall_len[s];
            end
        end
        cyc_i++;
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int i = 0;
        while (i < budget && (srcq[0].size() + srcq[1].size() + exp_q.size()) != 0) begin
            one_cycle();
            i++;
        end
        check({tag, "_bytes_left"}, exp_q.size(), 0);
        check({tag, "_src_left"}, srcq[0].size() + srcq[1].size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_tb_state();
        model_ptr = NS - 1;
        #2;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);

        // Single 4-byte packet: latency, tlast placement, grant lifetime.
        do_reset();
        add_pkt(0, 4, 8'h01, 0);
        build_expected();
        run_until_done("t1", 50);
        check("t1_grant_c0", tr_grant[0], 0);
        check("t1_valid_c1", tr_valid[1], 0);
        check("t1_grant_c1", tr_grant[1], 1);
        check("t1_busy_c1", tr_busy[1], 1);
        check("t1_valid_c2", tr_valid[2], 1);
        check("t1_grant_c4", tr_grant[4], 1);
        check("t1_last_c4", tr_last[4], 0);
        check("t1_last_c5", tr_last[5], 1);
        check("t1_grant_c5", tr_grant[5], 0);
        check("t1_busy_c5", tr_busy[5], 0);

        // Two simultaneous requesters: A then B then A again.
        do_reset();
        add_pkt(0, 3, 8'hA1, 0);
        add_pkt(0, 2, 8'hC1, 0);
        add_pkt(1, 3, 8'hB1, 0);
        build_expected();
        run_until_done("t2", 80);
        check("t2_grant_c1", tr_grant[1], 1);
        check("t2_grant_c5", tr_grant[5], 2);
        check("t2_grant_c9", tr_grant[9], 1);

        // Backpressure pattern 1,0,0 during a 5-byte packet.
        do_reset();
        tready_mode = 2;
        add_pkt(1, 5, 8'h50, 0);
        build_expected();
        run_until_done("t3", 80);

        // Source 0 stalls mid-packet; source 1 must wait for its tlast.
        do_reset();
        chk_hold_grant = 1;
        stall_after[0] = 2; stall_len[0] = 10;
        add_pkt(0, 4, 8'h10, 0);
        add_pkt(1, 3, 8'h20, 0);
        build_expected();
        run_until_done("t4", 100);

        // Asynchronous reset in the middle of a packet.
        do_reset();
        add_pkt(0, 6, 8'h60, 0);
        build_expected();
        for (int i = 0; i < 4; i++) one_cycle();
        check("t5_pre_valid", m_tvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_m_tvalid", m_tvalid, 0);
        check("t5_m_tdata", m_tdata, 0);
        check("t5_m_tlast", m_tlast, 0);
        check("t5_grant", grant, 0);
        check("t5_busy", busy, 0);
        check("t5_s_tready", s_tready, 0);
        clear_tb_state();
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = NS - 1;
        add_pkt(0, 2, 8'h70, 0);
        add_pkt(1, 2, 8'h80, 0);
        build_expected();
        run_until_done("t5", 60);

        // Randomized rounds: random lengths, data, stalls and backpressure.
        for (int r = 0; r < 8; r++) begin
            stall_pct = 20; tready_mode = 1; cyc_i = 0;
            for (int s = 0; s < NS; s++) begin
                int np = $urandom_range(0, 4);
                for (int p = 0; p < np; p++) add_pkt(s, $urandom_range(1, 6), 0, 1);
            end
            build_expected();
            run_until_done($sformatf("rnd%0d", r), 1500);
        end

`ifdef USB_ARB_TIMEOUT_EN
        // Stall past the timeout: delimiter emitted, rest of the packet swallowed.
        do_reset();
        stall_after[0] = 2; stall_len[0] = 30;
        add_pkt(0, 4, 8'h31, 0);
        exp_q.push_back(9'h031);
        exp_q.push_back(9'h032);
        exp_q.push_back(9'h100);
        model_ptr = 0;
        run_until_done("tmo", 120);
        check("tmo_err_set", timeout_err, 1);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        #1;
        check("tmo_err_cleared", timeout_err, 0);
        add_pkt(0, 2, 8'h41, 0);
        build_expected();
        run_until_done("tmo_after", 60);
`else
        check("timeout_err_tied", timeout_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/usb_stream_arbiter.md
Name: usb_stream_arbiter

Overview:
Packet-atomic round-robin arbiter sharing the single 8-bit USB FIFO write stream between several COBS-encoded packet sources, e.g. XADC sample packets and command responses. Each source is granted for one whole packet (through tlast) before re-arbitration, so frames never interleave. Sits between the COBS encoders and the USB FIFO bridge.

Parameters:
NUM_SOURCES, 2, number of requesting AXIS sources (2..8)
DATA_WIDTH, 8, byte width of every stream
TIMEOUT_CYCLES, 1024, mid-packet stall limit (used only with the optional feature)

Ports:
clk  in  1  shared stream clock
rst_n  in  1  asynchronous active-low reset
s_tdata  in  NUM_SOURCES*DATA_WIDTH  source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
s_tvalid  in  NUM_SOURCES  per-source valid
s_tlast  in  NUM_SOURCES  per-source end of packet
s_tready  out  NUM_SOURCES  per-source ready
m_tdata  out  DATA_WIDTH  output byte to USB FIFO
m_tvalid  out  1  output valid
m_tlast  out  1  output end of packet
m_tready  in  1  USB FIFO ready
grant  out  NUM_SOURCES  one-hot current owner, 0 when idle
busy  out  1  high while a packet is in flight
timeout_err  out  1  sticky stall flag
err_clear  in  1  clears timeout_err

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0, grant=0, busy=0, timeout_err=0; round-robin pointer=NUM_SOURCES-1, so source 0 wins first.
- States: IDLE, FORWARD, ABORT (ABORT exists only with the optional feature).
- IDLE: if any s_tvalid is set, choose the first requester searching from pointer+1 with wrap-around. Next cycle: grant one-hot, busy=1, pointer=winner, go to FORWARD. Arbitration costs exactly one cycle; there is no combinational path from s_tvalid to s_tready.
- FORWARD: s_tready[g] = (!m_tvalid || m_tready); all other s_tready bits are 0.
- On each s_tvalid[g] && s_tready[g] handshake, the byte and tlast are registered into the output stage. Latency is 1 cycle and throughput is 1 byte/cycle with no bubbles.
- m_tvalid/m_tdata/m_tlast hold stable until m_tready; the output is never withdrawn.
- Accepting a byte with s_tlast=1 makes the next state IDLE and clears grant and busy in the same cycle. The tail byte may still sit in the output register; IDLE may arbitrate while it drains.
- A source that deasserts tvalid mid-packet keeps its grant. Other requesters wait; there is no preemption.
- Simultaneous requests: round-robin order only, so each source gets at most one packet before any other waiting source is served.
- Single requester: back-to-back packets from the same source, with a 1-cycle gap for arbitration.
- A source whose tvalid drops while in IDLE before being granted is not granted.
- err_clear clears timeout_err; if a timeout fires in the same cycle, set wins.

Optional Feature:
USB_ARB_TIMEOUT_EN
- Enabled: a stall counter resets on every granted handshake and increments while in FORWARD with s_tvalid[g]=0.
- On reaching TIMEOUT_CYCLES: set timeout_err and go to ABORT.
- ABORT: emit one byte 0x00 with m_tlast=1 (COBS delimiter, so the host resynchronises); when it is accepted, go to IDLE. The source keeps a drop flag, and its later bytes are accepted (s_tready=1) and discarded through its tlast. A dropping source may be granted again only after that.
- Disabled: no counter or ABORT state; timeout_err tied 0; a stall holds the grant indefinitely.

Test Plan:
- Single source 0 sends a 4-byte packet 01 02 03 04 (tlast on 04) with m_tready=1: m_tdata 01..04 appears on consecutive cycles starting 2 cycles after the first s_tvalid; m_tlast only with 04; grant=01 then 00.
- Both sources hold 3-byte packets (A1..A3, B1..B3): output A1 A2 A3 B1 B2 B3; grant 01 then 10; then source 0 again if it still requests.
- m_tready toggles 1,0,0,1,... during a 5-byte packet: every byte is delivered exactly once, in order; m_tdata is stable while m_tvalid=1 and m_tready=0.
- Source 0 stalls after 2 of 4 bytes for 10 cycles while source 1 requests: source 1 is not granted until source 0's tlast; output bytes are contiguous per packet.
- rst_n is pulsed low mid-packet: all outputs are 0 immediately (asynchronously); after release, source 0 wins first.
- With USB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, source 0 stalls for 16 cycles mid-packet: output is 0x00 with tlast; timeout_err=1; the source's remaining bytes are swallowed; err_clear returns timeout_err to 0.
